// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL/DIVU/REMU (DATA_WIDTH steps).
// Result and Zero are registered on entry to DONE and held until the next DONE.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;    // MUL: shifted multiplicand; DIV: quotient/dividend
    logic [DATA_WIDTH-1:0] b_q;    // MUL: shifted multiplier;   DIV: divisor
    logic [DATA_WIDTH-1:0] acc_q;  // MUL: partial product;      DIV: partial remainder

    logic [DATA_WIDTH-1:0] single_res;
    logic [SHW-1:0]        sh;
    logic                  is_iter;

    always_comb begin
        sh         = B_i[SHW-1:0];
        single_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_res = A_i + B_i;
            OP_SUB:  single_res = A_i - B_i;
            OP_AND:  single_res = A_i & B_i;
            OP_OR:   single_res = A_i | B_i;
            OP_XOR:  single_res = A_i ^ B_i;
            OP_SLL:  single_res = A_i << sh;
            OP_SRL:  single_res = A_i >> sh;
            OP_SRA:  single_res = $unsigned($signed(A_i) >>> sh);
            OP_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OP_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, (A_i < B_i)};
            OP_LUI:  single_res = B_i;
            OP_DIVU: single_res = '1;  // only reached here with B == 0
            OP_REMU: single_res = A_i;
            default: single_res = '0;
        endcase
    end

    assign is_iter = (ALU_Operation_i == OP_MUL) ||
                     (((ALU_Operation_i == OP_DIVU) || (ALU_Operation_i == OP_REMU)) && (B_i != '0));

    // One iteration step of each algorithm, computed from current state.
    logic [DATA_WIDTH-1:0] mul_next;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;
    logic                  div_ge;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quot_next;
    logic [DATA_WIDTH-1:0] iter_res;

    always_comb begin
        mul_next  = acc_q + (b_q[0] ? a_q : '0);
        rem_sh    = {acc_q, a_q[DATA_WIDTH-1]};
        diff      = rem_sh - {1'b0, b_q};
        div_ge    = ~diff[DATA_WIDTH];
        rem_next  = div_ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        quot_next = {a_q[DATA_WIDTH-2:0], div_ge};
        case (op_q)
            OP_MUL:  iter_res = mul_next;
            OP_DIVU: iter_res = quot_next;
            default: iter_res = rem_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (start_i) begin
                        op_q   <= ALU_Operation_i;
                        a_q    <= A_i;
                        b_q    <= B_i;
                        acc_q  <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (is_iter) begin
                            state <= ITER;
                        end else begin
                            state        <= DONE;
                            done_o       <= 1'b1;
                            ALU_Result_o <= single_res;
                            Zero_o       <= (single_res == '0);
                        end
                    end
                end
                ITER: begin
                    busy_o <= 1'b1;
                    cnt    <= cnt + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_next;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        acc_q <= rem_next;
                        a_q   <= quot_next;
                    end
                    if (cnt == CW'(DATA_WIDTH-1)) begin
                        state        <= DONE;
                        done_o       <= 1'b1;
                        ALU_Result_o <= iter_res;
                        Zero_o       <= (iter_res == '0);
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus random ops vs. arithmetic model.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
        .A_i(A_i), .B_i(B_i), .busy_o(busy_o), .done_o(done_o),
        .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = $unsigned($signed(a) >>> sh);
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = b;
            4'd11: r = a * b;
            4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: r = (b == 0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd11) return 33;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return 33;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs afterwards, then check latency, result, Zero and the follow-up IDLE cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp_r;
        int exp_l;
        int lat;
        exp_r = ref_alu(op, a, b);
        exp_l = ref_lat(op, b);
        @(negedge clk);
        start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
        @(negedge clk);
        start_i = 1'b0; ALU_Operation_i = 4'($urandom); A_i = $urandom; B_i = $urandom;
        lat = 1;
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        while (!done_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_l));
        chk({tag, "_res"}, ALU_Result_o, exp_r);
        chk({tag, "_zero"}, 32'(Zero_o), 32'(exp_r == 0));
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
        chk({tag, "_hold"}, ALU_Result_o, exp_r);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int dones;
        logic [31:0] exp_r;
        int lat;

        reset = 1'b1; start_i = 1'b0; ALU_Operation_i = 4'd0; A_i = '0; B_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_res", ALU_Result_o, 32'd0);
        chk("reset_zero", 32'(Zero_o), 32'd1);

        run_op(4'd1, 32'd5, 32'd5, "sub55");
        run_op(4'd11, 32'h0000_1234, 32'h0000_0100, "mul1");
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
        run_op(4'd12, 32'd100, 32'd7, "divu");
        run_op(4'd13, 32'd100, 32'd7, "remu");
        run_op(4'd12, 32'd5, 32'd0, "divu0");
        run_op(4'd13, 32'd5, 32'd0, "remu0");
        run_op(4'd7, 32'h8000_0000, 32'h0000_0024, "sra");
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, "slt");
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_op(4'd14, 32'd3, 32'd4, "rsv14");
        run_op(4'd15, 32'hFFFF_FFFF, 32'd1, "rsv15");
        run_op(4'd0, 32'hFFFF_FFFF, 32'd2, "add_wrap");
        run_op(4'd12, 32'hFFFF_FFFF, 32'd1, "divu_max");

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
        end

        // start while busy is ignored
        exp_r = ref_alu(4'd11, 32'd1000, 32'd77);
        @(negedge clk);
        start_i = 1'b1; ALU_Operation_i = 4'd11; A_i = 32'd1000; B_i = 32'd77;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1; dones = 0;
        while (lat < 45) begin
            if (lat == 5) begin
                start_i = 1'b1; ALU_Operation_i = 4'd0; A_i = 32'd1; B_i = 32'd2;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                dones++;
                chk("ignore_lat", 32'(lat), 32'd33);
                chk("ignore_res", ALU_Result_o, exp_r);
            end
            @(negedge clk);
            lat++;
        end
        chk("ignore_dones", 32'(dones), 32'd1);

        // reset aborts an in-flight MUL
        @(negedge clk);
        start_i = 1'b1; ALU_Operation_i = 4'd11; A_i = 32'd3; B_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_res", ALU_Result_o, 32'd0);
        chk("abort_zero", 32'(Zero_o), 32'd1);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        chk("abort_nodone", 32'(dones), 32'd0);

        // start coincident with reset is discarded
        reset = 1'b1; start_i = 1'b1; ALU_Operation_i = 4'd10; A_i = 32'd0; B_i = 32'h55;
        @(negedge clk);
        reset = 1'b0; start_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            if (done_o || busy_o) dones++;
            @(negedge clk);
        end
        chk("rst_start_discard", 32'(dones), 32'd0);
        chk("rst_start_res", ALU_Result_o, 32'd0);

        run_op(4'd10, 32'd0, 32'hDEAD_0000, "lui_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
